// File: rtl/bram_stream_loader.sv
// Byte-stream BRAM loader: assembles bytes little-endian into words and writes
// them to consecutive addresses starting at 0, for a requested word count.
module bram_stream_loader #(
  parameter int memSize_p   = 8,
  parameter int dataWidth_p = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [memSize_p:0]     length_i,
  input  logic [7:0]             byte_i,
  input  logic                   byte_valid_i,
  output logic                   byte_ready_o,
  output logic                   wr_en_o,
  output logic [memSize_p-1:0]   wr_addr_o,
  output logic [dataWidth_p-1:0] wr_data_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int BYTES  = dataWidth_p / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [memSize_p:0]  DEPTH     = {1'b1, {memSize_p{1'b0}}};
  localparam logic [BCNT_W-1:0]   BCNT_LAST = BCNT_W'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_e;

  state_e                 state_q;
  logic [memSize_p:0]     len_q;
  logic [memSize_p:0]     wcnt_q;
  logic [BCNT_W-1:0]      bcnt_q;
  logic [dataWidth_p-1:0] asm_q;

  logic                   byte_ready_q;
  logic                   wr_en_q;
  logic [memSize_p-1:0]   wr_addr_q;
  logic [dataWidth_p-1:0] wr_data_q;
  logic                   busy_q;
  logic                   done_q;

  logic [memSize_p:0]     len_d;
  logic [memSize_p:0]     wcnt_d;
  logic [dataWidth_p-1:0] asm_d;

  // Requests beyond the memory depth are clamped so the load never wraps.
  assign len_d  = (length_i > DEPTH) ? DEPTH : length_i;
  assign wcnt_d = wcnt_q + (memSize_p + 1)'(1);

  always_comb begin
    // NOTE: default assignment first so every path drives asm_d and no latch is inferred.
    asm_d = asm_q;
    for (int b = 0; b < BYTES; b++) begin
      if (bcnt_q == BCNT_W'(b)) asm_d[8*b +: 8] = byte_i;
    end
  end

  // Outputs are registered alongside the state so no input reaches an output
  // combinationally; wr_addr_q/wr_data_q hold between writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (rst_i) begin
      state_q      <= IDLE;
      len_q        <= '0;
      wcnt_q       <= '0;
      bcnt_q       <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            len_q     <= len_d;
            wcnt_q    <= '0;
            bcnt_q    <= '0;
            asm_q     <= '0;
            wr_addr_q <= '0;
            busy_q    <= 1'b1;
            if (len_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= RECV;
              byte_ready_q <= 1'b1;
            end
          end
        end
        RECV: begin
          if (byte_valid_i) begin
            asm_q <= asm_d;
            if (bcnt_q == BCNT_LAST) begin
              bcnt_q       <= '0;
              state_q      <= WRITE;
              byte_ready_q <= 1'b0;
              wr_en_q      <= 1'b1;
              wr_addr_q    <= wcnt_q[memSize_p-1:0];
              wr_data_q    <= asm_d;
            end else begin
              bcnt_q <= bcnt_q + BCNT_W'(1);
            end
          end
        end
        WRITE: begin
          wcnt_q <= wcnt_d;
          if (wcnt_d == len_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q      <= RECV;
            byte_ready_q <= 1'b1;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          byte_ready_q <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          byte_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready_o = byte_ready_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_bram_stream_loader.sv
// Self-checking bench for bram_stream_loader: a cycle-level expectation model
// built from the handshake/latency rules plus directed load scenarios.
module tb_bram_stream_loader;

  localparam int M     = 2;
  localparam int DW    = 16;
  localparam int BYTES = DW / 8;
  localparam int DEPTH = 1 << M;

  logic          clk_i        = 1'b0;
  logic          rst_i        = 1'b0;
  logic          start_i      = 1'b0;
  logic [M:0]    length_i     = '0;
  logic [7:0]    byte_i       = '0;
  logic          byte_valid_i = 1'b0;
  logic          byte_ready_o;
  logic          wr_en_o;
  logic [M-1:0]  wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          busy_o;
  logic          done_o;

  always #5 clk_i = ~clk_i;

  bram_stream_loader #(.memSize_p(M), .dataWidth_p(DW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .length_i     (length_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr[$];
  logic [DW-1:0] bram [DEPTH];
  logic [7:0]    src  [16];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_writes = 0;

  // Expectation model: which cycle each output must be active in.
  bit m_busy, m_wr_due, m_done_due;
  int m_bytes, m_words, m_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ready"}, byte_ready_o, 0);
    check({tag, "_wr_en"}, wr_en_o, 0);
    check({tag, "_addr"},  wr_addr_o, 0);
    check({tag, "_data"},  wr_data_o, 0);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_done"},  done_o, 0);
  endtask

  always @(negedge clk_i) begin
    bit  n_busy, n_wr_due, n_done_due, ready_m;
    wr_t w;
    if (rst_i) begin
      check_outputs_zero("in_reset");
      m_busy = 0; m_wr_due = 0; m_done_due = 0;
      m_bytes = 0; m_words = 0; m_len = 0;
    end else begin
      ready_m = m_busy && !m_wr_due && !m_done_due;
      check("busy",  busy_o, m_busy);
      check("ready", byte_ready_o, ready_m);
      check("wr_en", wr_en_o, m_wr_due);
      check("done",  done_o, m_done_due);
      if (wr_en_o) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", wr_addr_o, w.addr);
          check("wr_data", wr_data_o, w.data);
        end
        bram[wr_addr_o] = wr_data_o;
        n_writes++;
      end
      n_busy = m_busy; n_wr_due = 0; n_done_due = 0;
      if (!m_busy && start_i) begin
        m_len   = clamp(int'(length_i));
        m_bytes = 0;
        m_words = 0;
        n_busy  = 1;
        if (m_len == 0) n_done_due = 1;
      end
      if (ready_m && byte_valid_i) begin
        m_bytes++;
        if (m_bytes % BYTES == 0) n_wr_due = 1;
      end
      if (m_wr_due) begin
        m_words++;
        if (m_words == m_len) n_done_due = 1;
      end
      if (m_done_due) n_busy = 0;
      m_busy = n_busy; m_wr_due = n_wr_due; m_done_due = n_done_due;
    end
  end

  // Start a load of len words offering src[0..nbytes-1]; gap!=0 inserts random
  // idle cycles; glitch_cyc re-pulses start with length 1; stop_at aborts early.
  task automatic load(input int len, input int nbytes, input int gap,
                      input int glitch_cyc, input int stop_at, output int consumed);
    int cl  = clamp(len);
    int w0  = n_writes;
    int idx = 0;
    bit got_done = 0;
    bit fire;
    for (int w = 0; w < cl; w++) exp_wr.push_back('{w, {src[2*w+1], src[2*w]}});
    @(posedge clk_i); #1;
    start_i  = 1'b1;
    length_i = (M + 1)'(len);
    @(posedge clk_i); #1;
    start_i  = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      byte_valid_i = (idx < nbytes) && (gap == 0 || $urandom_range(0, 2) != 0);
      byte_i       = (idx < nbytes) ? src[idx] : 8'h00;
      if (cyc == glitch_cyc) begin
        start_i  = 1'b1;
        length_i = (M + 1)'(1);
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      fire = byte_valid_i && byte_ready_o;
      if (done_o) got_done = 1;
      @(posedge clk_i); #1;
      if (fire) idx++;
      if (got_done || idx == stop_at) break;
    end
    byte_valid_i = 1'b0;
    start_i      = 1'b0;
    consumed     = idx;
    if (stop_at < 0) begin
      check("done_seen", got_done, 1);
      check("bytes_consumed", idx, cl * BYTES);
      check("write_count", n_writes - w0, cl);
      check("queue_drained", exp_wr.size(), 0);
    end
  endtask

  initial begin
    int cons, w0;
    #1 rst_i = 1'b1;
    #2 check_outputs_zero("async_reset");
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Two words back-to-back, little-endian assembly.
    src[0] = 8'h34; src[1] = 8'h12; src[2] = 8'h78; src[3] = 8'h56;
    load(2, 4, 0, -1, -1, cons);
    check("lit_word0", bram[0], 16'h1234);
    check("lit_word1", bram[1], 16'h5678);

    // Zero-length load with a byte offered: nothing consumed, no writes.
    w0 = n_writes;
    load(0, 1, 0, -1, -1, cons);
    check("lit_len0_writes", n_writes - w0, 0);

    // Over-length request clamps to the full depth.
    for (int i = 0; i < 10; i++) src[i] = 8'(i + 1);
    w0 = n_writes;
    load(7, 10, 0, -1, -1, cons);
    check("lit_clamp_writes", n_writes - w0, 4);
    check("lit_clamp_last", bram[3], 16'h0807);

    // Random source gaps.
    for (int i = 0; i < 8; i++) src[i] = 8'(8'h40 + i * 3);
    load(4, 8, 1, -1, -1, cons);

    // Start pulsed mid-load with another length is ignored.
    for (int i = 0; i < 6; i++) src[i] = 8'(8'hc0 + i);
    w0 = n_writes;
    load(3, 6, 0, 2, -1, cons);
    check("lit_glitch_writes", n_writes - w0, 3);

    // Reset after three words plus one byte of the fourth.
    for (int i = 0; i < 8; i++) src[i] = 8'(8'h90 + i);
    w0 = n_writes;
    load(4, 8, 0, -1, 7, cons);
    check("abort_consumed", cons, 7);
    check("abort_writes", n_writes - w0, 3);
    #2 rst_i = 1'b1;
    byte_valid_i = 1'b0;
    #1 check_outputs_zero("mid_load_reset");
    exp_wr.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("lit_kept_word2", bram[2], 16'h9594);

    // Fresh load after the abort starts again at address 0.
    src[0] = 8'ha1; src[1] = 8'hb2; src[2] = 8'hc3; src[3] = 8'hd4;
    load(2, 4, 0, -1, -1, cons);
    check("lit_reload0", bram[0], 16'hb2a1);
    check("lit_reload1", bram[1], 16'hd4c3);

    repeat (3) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
